// File: rtl/soc_system_pulse_out.sv
// Avalon-MM output PIO: static level register ORed with a hardware-timed one-shot pulse.
// A done flag with maskable level interrupt marks the end of each pulse.
//
//   state | meaning
//   IDLE  | no pulse active, PULSE writes with nonzero bits are accepted
//   PULSE | pulse_bits driven, cnt counting down to the final cycle
module soc_system_pulse_out #(
    parameter int WIDTH      = 8,
    parameter int CNT_W      = 16,
    parameter int LEN_RESET  = 1000,
    parameter int DATA_RESET = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    output logic [WIDTH-1:0] out_port
);

    typedef enum logic {IDLE, PULSE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_reg;
    logic [WIDTH-1:0]   pulse_bits;
    logic [CNT_W-1:0]   len_reg;
    logic [CNT_W-1:0]   cnt;
    logic               done;
    logic               irq_mask;
    logic               wr;
    logic               start;
    logic               finish;
    logic               busy;
    logic [31:0]        rd_mux;
    logic               unused_wd;

    assign wr        = chipselect & ~write_n;
    assign busy      = (state_q == PULSE);
    assign unused_wd = ^writedata;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr && address == 2'd1 && writedata[WIDTH-1:0] != '0) begin
                    start   = 1'b1;
                    state_d = PULSE;
                end
            end
            PULSE: begin
                if (cnt == CNT_W'(1)) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt        <= '0;
            pulse_bits <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                pulse_bits <= writedata[WIDTH-1:0];
                // A zero length still yields a single-cycle strobe.
                cnt        <= (len_reg == '0) ? CNT_W'(1) : len_reg;
            end else if (finish) begin
                pulse_bits <= '0;
            end else if (busy) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= WIDTH'(DATA_RESET);
            len_reg  <= CNT_W'(LEN_RESET);
            done     <= 1'b0;
            irq_mask <= 1'b0;
        end else begin
            if (wr && address == 2'd0) data_reg <= writedata[WIDTH-1:0];
            if (wr && address == 2'd2) len_reg  <= writedata[CNT_W-1:0];
            if (wr && address == 2'd3) irq_mask <= writedata[1];
            // Pulse completion takes priority over a same-cycle clear.
            if (finish)
                done <= 1'b1;
            else if (wr && address == 2'd3 && writedata[0])
                done <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0: rd_mux[WIDTH-1:0] = data_reg;
            2'd1: begin
                rd_mux[WIDTH-1:0] = pulse_bits;
                rd_mux[WIDTH]     = busy;
            end
            2'd2: rd_mux[CNT_W-1:0] = len_reg;
            2'd3: rd_mux[1:0] = {irq_mask, done};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_mux;
    end

    assign irq      = done & irq_mask;
    assign out_port = data_reg | pulse_bits;

endmodule

// File: tb/tb_soc_system_pulse_out.sv
// Directed bench for soc_system_pulse_out: register map, pulse timing, collisions and async reset.
module tb_soc_system_pulse_out;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;
    logic [7:0]  out_port;

    int errors = 0;
    int checks = 0;

    soc_system_pulse_out dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Called and returns at 1 time unit after a rising edge.
    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic do_read(input logic [1:0] a, output logic [31:0] rd);
        address = a;
        @(posedge clk); #1;
        rd = readdata;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          hi;
        logic        saw1;

        // Reset state
        step(3);
        check("rst_out_port", {24'h0, out_port}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1;
        step(1);
        do_read(2'd0, rd); check("rst_data", rd, 32'h0);
        do_read(2'd1, rd); check("rst_pulse", rd, 32'h0);
        do_read(2'd2, rd); check("rst_len", rd, 32'd1000);
        do_read(2'd3, rd); check("rst_status", rd, 32'h0);

        // Static level register
        do_write(2'd0, 32'hFFFF_FFA5);
        check("data_out_port", {24'h0, out_port}, 32'hA5);
        do_read(2'd0, rd); check("data_read", rd, 32'hA5);

        // 5-cycle pulse on bits 1:0, interrupt unmasked
        do_write(2'd2, 32'd5);
        do_write(2'd3, 32'h2);
        do_write(2'd1, 32'h03);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_port[1:0] == 2'b11) hi++;
            if (i == 1) check("pulse_busy_rb", readdata, 32'h103);
            @(posedge clk); #1;
        end
        check("pulse5_width", hi, 5);
        check("pulse5_out_after", {24'h0, out_port}, 32'hA5);
        check("pulse5_irq", {31'h0, irq}, 32'h1);
        do_read(2'd3, rd); check("pulse5_status", rd, 32'h3);
        do_write(2'd3, 32'h3);
        check("w1c_irq", {31'h0, irq}, 32'h0);
        do_read(2'd3, rd); check("w1c_status", rd, 32'h2);

        // Zero length gives a one-cycle pulse
        do_write(2'd0, 32'h0);
        do_write(2'd2, 32'h0);
        do_write(2'd1, 32'h80);
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_port[7]) hi++;
            @(posedge clk); #1;
        end
        check("len0_width", hi, 1);
        do_read(2'd3, rd); check("len0_status", rd, 32'h3);
        do_write(2'd3, 32'h1);
        do_read(2'd3, rd); check("len0_clear", rd, 32'h0);

        // Zero-bit pulse write is ignored
        do_write(2'd1, 32'h0);
        check("zero_out_port", {24'h0, out_port}, 32'h0);
        do_read(2'd1, rd); check("zero_busy", rd, 32'h0);
        step(3);
        do_read(2'd3, rd); check("zero_done", rd, 32'h0);

        // Retrigger while busy is ignored; DATA write applies immediately
        do_write(2'd2, 32'd10);
        do_write(2'd1, 32'h01);          // accepted at edge E0
        saw1 = out_port[1];
        step(2);
        saw1 |= out_port[1];
        do_write(2'd1, 32'h02);          // E3
        saw1 |= out_port[1];
        do_write(2'd0, 32'h01);          // E4
        saw1 |= out_port[1];
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            saw1 |= out_port[1];
        end
        do_read(2'd1, rd); check("retrig_last_cycle", rd, 32'h101);
        saw1 |= out_port[1];
        do_read(2'd1, rd); check("retrig_idle", rd, 32'h0);
        check("retrig_bit1", {31'h0, saw1}, 32'h0);
        check("retrig_out_after", {24'h0, out_port}, 32'h01);
        check("retrig_irq_masked", {31'h0, irq}, 32'h0);
        do_read(2'd3, rd); check("retrig_done", rd, 32'h1);
        do_write(2'd3, 32'h1);

        // Async reset mid-pulse
        do_write(2'd1, 32'h02);
        step(3);
        #2 reset_n = 1'b0;
        #1 check("areset_out_port", {24'h0, out_port}, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(1);
        do_read(2'd1, rd); check("areset_busy", rd, 32'h0);
        do_read(2'd3, rd); check("areset_status", rd, 32'h0);
        do_read(2'd2, rd); check("areset_len", rd, 32'd1000);

        // done set and W1C on the same edge: set wins
        do_write(2'd2, 32'd2);
        do_write(2'd3, 32'h2);
        do_write(2'd1, 32'h04);          // E0
        step(1);                         // E1
        do_write(2'd3, 32'h3);           // E2, pulse-end edge
        do_read(2'd3, rd); check("collide_status", rd, 32'h3);
        check("collide_irq", {31'h0, irq}, 32'h1);
        do_write(2'd3, 32'h3);
        do_read(2'd3, rd); check("collide_clear", rd, 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/soc_system_pulse_out.md
Name: soc_system_pulse_out

Overview:
- Avalon-MM slave output PIO that drives a WIDTH-bit out_port toward robot actuators, e.g. the raise/grip solenoid drivers.
- Provides two output sources:
  - a static level register;
  - a hardware-timed one-shot pulse generator, so the HPS can issue fixed-width strobes without software timing.
- A completion flag with a maskable interrupt signals the end of each pulse.
- Sits in soc_system on the lightweight HPS-to-FPGA bridge, alongside the input PIOs.

Parameters:
- WIDTH, 8, number of output bits on out_port.
- CNT_W, 16, width of the pulse-length register and down-counter.
- LEN_RESET, 1000, reset value of PULSE_LEN (clock cycles).
- DATA_RESET, 0, reset value of the DATA register.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  interrupt, level, active-high.
- out_port  out  WIDTH  drive to pins = data_reg | pulse_bits.

Behaviour:
- Write condition: wr = chipselect & ~write_n. Reads have no side effects.
- readdata is registered every clk from address, giving 1-cycle read latency. Unused bits read 0. Reset value 0.
- Register map:
  - Addr 0, DATA (R/W): data_reg <= writedata[WIDTH-1:0].
  - Addr 1, PULSE: write starts a pulse. Read returns {busy, pulse_bits} in bits [WIDTH], [WIDTH-1:0].
  - Addr 2, PULSE_LEN (R/W): len_reg <= writedata[CNT_W-1:0].
  - Addr 3, STATUS: bit0 = done (write 1 to clear), bit1 = irq_mask (R/W). The same write updates both.
- Reset values: data_reg = DATA_RESET, len_reg = LEN_RESET, pulse_bits = 0, cnt = 0, done = 0, irq_mask = 0, state = IDLE, out_port = DATA_RESET, irq = 0.
- FSM, two states, IDLE and PULSE. busy = (state == PULSE).
- IDLE: on a wr to addr 1 with writedata[WIDTH-1:0] != 0:
  - pulse_bits <= writedata[WIDTH-1:0];
  - cnt <= (len_reg == 0) ? 1 : len_reg;
  - go to PULSE.
- A write of zero bits to addr 1 is ignored: no state change, done not set.
- PULSE: each clk, cnt <= cnt - 1. At the edge where cnt == 1:
  - pulse_bits <= 0;
  - done <= 1;
  - go to IDLE.
- Pulse width is therefore exactly max(len_reg, 1) cycles of out_port high. The pulse begins on the first cycle after the accepting write edge.
- Writes to addr 1 while busy are ignored: no retrigger, no queueing.
- Writes to PULSE_LEN while busy update len_reg only. The current pulse is unaffected.
- Writes to DATA while busy take effect immediately. out_port is the OR of data_reg and pulse_bits, so a pulsed bit stays high if its data_reg bit is set.
- Simultaneous done set (pulse end) and W1C write of done: set wins, done = 1.
- irq = done & irq_mask. It is combinational from the registers and holds until cleared or masked.
- Asynchronous reset asserted mid-pulse:
  - out_port returns to DATA_RESET immediately;
  - FSM returns to IDLE;
  - done stays 0.
- No counter wrap: cnt never decrements below 1 in PULSE. cnt is don't-care in IDLE.

Test Plan:
- Reset, then read all four addresses -> DATA = 0, PULSE = 0 (busy 0), PULSE_LEN = 1000, STATUS = 0; out_port = 0; irq = 0.
- Write DATA = 0xA5, read addr 0 -> readdata = 0xA5 one cycle after the read; out_port = 0xA5 from the cycle after the write.
- Write PULSE_LEN = 5, STATUS = 0x2, PULSE = 0x03 -> out_port[1:0] high exactly 5 cycles; PULSE readback bit8 = 1 during the pulse; then done = 1 and irq = 1; write STATUS = 0x3 -> irq = 0.
- PULSE_LEN = 0, PULSE = 0x80 -> out_port[7] high exactly 1 cycle. PULSE write of 0x00 -> no pulse, done stays 0.
- PULSE_LEN = 10, PULSE = 0x01; at cycle 3 write PULSE = 0x02 and DATA = 0x01 -> the second pulse is ignored; out_port[0] stays 1 after the pulse ends; out_port[1] never asserts.
- At cycle 4 of a 10-cycle pulse assert reset_n = 0 -> out_port = 0 asynchronously; after release busy = 0 and done = 0. Separately, a W1C of done on the exact pulse-end edge -> done reads 1.
